// File: rtl/signed_accum_ovf_pkg.sv
// Shared types and the W-bit two's-complement add/overflow helper for signed_accum_ovf.
// Supports widths up to MAX_W; callers zero-extend operands and keep the low W bits.
package signed_accum_pkg;

    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_IW = $clog2(MAX_W);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Returns {ovf, sum}; only bits [w-1:0] of sum are meaningful.
    function automatic logic [MAX_W:0] add_ovf(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int unsigned      w);
        logic [MAX_W-1:0]  sum;
        logic [MAX_IW-1:0] msb;
        logic              ovf;
        msb = MAX_IW'(w - 1);
        sum = a + b;
        ovf = (a[msb] == b[msb]) && (sum[msb] != a[msb]);
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/signed_accum_ovf_if.sv
// Sample/flush/result bus of signed_accum_ovf; the accumulator is the slave.
interface signed_accum_ovf_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf_sticky;
    logic             ovf_pulse;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf_sticky, ovf_pulse
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf_sticky, ovf_pulse
    );

endinterface

// File: rtl/signed_accum_ovf_add.sv
// Combinational W-bit signed add with overflow flag.
// SIGNED_ACCUM_OVF_SAT_EN: clamp the sum to the signed range on overflow instead of wrapping.
module signed_add_ovf
    import signed_accum_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum_c,
    output logic         ovf_c
);

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;

    always_comb begin
        a_ext = MAX_W'(a);
        b_ext = MAX_W'(b);
        ovf_c = 1'(add_ovf(a_ext, b_ext, W) >> MAX_W);
        sum_c = W'(add_ovf(a_ext, b_ext, W));
`ifdef SIGNED_ACCUM_OVF_SAT_EN
        // Overflow implies equal operand signs, so a's sign picks the rail.
        if (ovf_c) begin
            sum_c = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

endmodule

// File: rtl/signed_accum_ovf.sv
// Signed running-sum accumulator with overflow tracking, saturating sample count and flush handoff.
// Build option SIGNED_ACCUM_OVF_SAT_EN selects saturating instead of wrapping accumulation.
module signed_accum_ovf
    import signed_accum_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              areset,
    signed_accum_ovf_if.slave bus
);

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_sticky_q, out_sticky_d;
    logic             ovf_pulse_q, ovf_pulse_d;
    logic [W-1:0]     add_sum_c;
    logic             add_ovf_c;

    signed_add_ovf #(.W(W)) u_add (
        .a     (acc_q),
        .b     (bus.in_data),
        .sum_c (add_sum_c),
        .ovf_c (add_ovf_c)
    );

    // Next-state: a same-cycle sample is folded in before a flush snapshots the totals.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        sticky_d     = sticky_q;
        out_valid_d  = out_valid_q;
        out_sum_d    = out_sum_q;
        out_count_d  = out_count_q;
        out_sticky_d = out_sticky_q;
        ovf_pulse_d  = 1'b0;
        case (state_q)
            ACC: begin
                if (bus.in_valid) begin
                    acc_d       = add_sum_c;
                    count_d     = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
                    sticky_d    = sticky_q | add_ovf_c;
                    ovf_pulse_d = add_ovf_c;
                end
                if (bus.flush) begin
                    out_sum_d    = acc_d;
                    out_count_d  = count_d;
                    out_sticky_d = sticky_d;
                    acc_d        = '0;
                    count_d      = '0;
                    sticky_d     = 1'b0;
                    out_valid_d  = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= ACC;
            acc_q        <= '0;
            count_q      <= '0;
            sticky_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
            out_count_q  <= '0;
            out_sticky_q <= 1'b0;
            ovf_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            sticky_q     <= sticky_d;
            out_valid_q  <= out_valid_d;
            out_sum_q    <= out_sum_d;
            out_count_q  <= out_count_d;
            out_sticky_q <= out_sticky_d;
            ovf_pulse_q  <= ovf_pulse_d;
        end
    end

    assign bus.in_ready       = (state_q == ACC);
    assign bus.out_valid      = out_valid_q;
    assign bus.out_sum        = out_sum_q;
    assign bus.out_count      = out_count_q;
    assign bus.out_ovf_sticky = out_sticky_q;
    assign bus.ovf_pulse      = ovf_pulse_q;

endmodule

// File: tb/tb_signed_accum_ovf.sv
// Bench for signed_accum_ovf: directed cases plus randomized traffic against an integer model.
// Honours SIGNED_ACCUM_OVF_SAT_EN when computing expected sums.
module tb_signed_accum_ovf;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned C2_W  = 2;
    localparam int MAXV = 2 ** (W - 1) - 1;
    localparam int MINV = -(2 ** (W - 1));
    localparam int CMAX = 2 ** CNT_W - 1;

`ifdef SIGNED_ACCUM_OVF_SAT_EN
    localparam logic [7:0] EXP_POS = 8'h7F;
    localparam logic [7:0] EXP_NEG = 8'h80;
`else
    localparam logic [7:0] EXP_POS = 8'h80;
    localparam logic [7:0] EXP_NEG = 8'h20;
`endif

    logic clk;
    logic areset;
    int   n_vec;
    int   n_err;

    signed_accum_ovf_if #(.W(W), .CNT_W(CNT_W)) bus  ();
    signed_accum_ovf_if #(.W(W), .CNT_W(C2_W))  bus2 ();

    signed_accum_ovf #(.W(W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    signed_accum_ovf #(.W(W), .CNT_W(C2_W)) dut_c2 (
        .clk    (clk),
        .areset (areset),
        .bus    (bus2)
    );

    always #5 clk = ~clk;

    // Reference model: signed integers, clamped or wrapped into the W-bit range.
    int m_acc, m_cnt, m_osum, m_ocnt;
    bit m_sticky, m_pulse, m_hold, m_ovalid, m_osticky;

    function automatic void model_reset();
        m_acc = 0; m_cnt = 0; m_sticky = 0; m_pulse = 0;
        m_hold = 0; m_ovalid = 0; m_osum = 0; m_ocnt = 0; m_osticky = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [W-1:0] d, input bit f, input bit r);
        int s;
        bit o;
        m_pulse = 0;
        if (!m_hold) begin
            if (v) begin
                s = m_acc + int'($signed(d));
                o = (s > MAXV) || (s < MINV);
                if (o) begin
`ifdef SIGNED_ACCUM_OVF_SAT_EN
                    s = (s > MAXV) ? MAXV : MINV;
`else
                    s = (s > MAXV) ? s - 2 ** W : s + 2 ** W;
`endif
                end
                m_acc    = s;
                m_sticky = m_sticky | o;
                m_pulse  = o;
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end
            if (f) begin
                m_osum = m_acc; m_ocnt = m_cnt; m_osticky = m_sticky;
                m_acc = 0; m_cnt = 0; m_sticky = 0;
                m_ovalid = 1; m_hold = 1;
            end
        end else if (r) begin
            m_ovalid = 0;
            m_hold   = 0;
        end
    endfunction

    task automatic cycle(input bit v, input logic [W-1:0] d, input bit f, input bit r);
        bus.in_valid = v; bus.in_data = d; bus.flush = f; bus.out_ready = r;
        @(posedge clk);
        model_step(v, d, f, r);
        #1;
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 0;
    endtask

    task automatic do_reset();
        areset = 1;
        @(posedge clk);
        #1;
        areset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        areset = 0;
        #1 areset = 1;
        #2;
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.ovf_pulse, bus.in_ready}
            !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_main: got v=%b s=%h c=%h st=%b p=%b rdy=%b, need 0 00 00 0 0 1",
                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.ovf_pulse, bus.in_ready);
        end
        n_vec++;
        if ({bus2.out_valid, bus2.out_sum, bus2.out_count, bus2.out_ovf_sticky, bus2.in_ready}
            !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_c2: got v=%b s=%h c=%0d st=%b rdy=%b, need 0 00 0 0 1",
                     bus2.out_valid, bus2.out_sum, bus2.out_count, bus2.out_ovf_sticky, bus2.in_ready);
        end
        @(posedge clk);
        #1 areset = 0;
        model_reset();
    endtask

    task automatic test_ovf_pos();
        do_reset();
        cycle(1, 8'h70, 0, 0);
        cycle(1, 8'h10, 0, 0);
        n_vec++;
        if ({bus.ovf_pulse, bus.in_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL pos_pulse: got p=%b rdy=%b, need 1 1", bus.ovf_pulse, bus.in_ready);
        end
        cycle(0, 8'h00, 1, 0);
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready, bus.ovf_pulse}
            !== {1'b1, EXP_POS, 8'd2, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL pos_flush: got v=%b s=%h c=%0d st=%b rdy=%b p=%b, need 1 %h 2 1 0 0",
                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready, bus.ovf_pulse, EXP_POS);
        end
        cycle(0, 8'h00, 0, 1);
        n_vec++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL pos_release: got v=%b rdy=%b, need 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_ovf_neg();
        do_reset();
        cycle(1, 8'h90, 0, 0);
        cycle(1, 8'h90, 0, 0);
        cycle(0, 8'h00, 1, 0);
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky} !== {1'b1, EXP_NEG, 8'd2, 1'b1}) begin
            n_err++;
            $display("FAIL neg_flush: got v=%b s=%h c=%0d st=%b, need 1 %h 2 1",
                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, EXP_NEG);
        end
        cycle(0, 8'h00, 0, 1);
        cycle(1, 8'h90, 0, 0);
        cycle(1, 8'h70, 0, 0);
        n_vec++;
        if (bus.ovf_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL mixed_pulse: got %b, need 0", bus.ovf_pulse);
        end
        cycle(0, 8'h00, 1, 0);
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky} !== {1'b1, 8'h00, 8'd2, 1'b0}) begin
            n_err++;
            $display("FAIL mixed_flush: got v=%b s=%h c=%0d st=%b, need 1 00 2 0",
                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky);
        end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_flush_same_cycle();
        do_reset();
        cycle(1, 8'h03, 0, 0);
        cycle(1, 8'h05, 1, 0);
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready}
            !== {1'b1, 8'h08, 8'd2, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL same_cycle: got v=%b s=%h c=%0d st=%b rdy=%b, need 1 08 2 0 0",
                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready);
        end
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 1, 0);
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky} !== {1'b1, 8'h00, 8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL empty_flush: got v=%b s=%h c=%0d st=%b, need 1 00 0 0",
                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky);
        end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_hold();
        do_reset();
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, W'($urandom), 1, 0);
            n_vec++;
            if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready}
                !== {1'b1, 8'h33, 8'd2, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: got v=%b s=%h c=%0d st=%b rdy=%b, need 1 33 2 0 0", i,
                         bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready);
            end
        end
        cycle(0, 8'h00, 0, 1);
        n_vec++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release: got v=%b rdy=%b, need 0 1", bus.out_valid, bus.in_ready);
        end
        cycle(1, 8'h01, 1, 0);
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count} !== {1'b1, 8'h01, 8'd1}) begin
            n_err++;
            $display("FAIL hold_ignored: got v=%b s=%h c=%0d, need 1 01 1",
                     bus.out_valid, bus.out_sum, bus.out_count);
        end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        cycle(1, 8'h7F, 0, 0);
        cycle(1, 8'h7F, 1, 0);
        n_vec++;
        if ({bus.out_valid, bus.out_ovf_sticky} !== 2'b11) begin
            n_err++;
            $display("FAIL pre_reset_hold: got v=%b st=%b, need 1 1", bus.out_valid, bus.out_ovf_sticky);
        end
        #1 areset = 1;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready, bus.ovf_pulse}
            !== {1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got v=%b s=%h c=%0d st=%b rdy=%b p=%b, need 0 00 0 0 1 0",
                     bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf_sticky, bus.in_ready, bus.ovf_pulse);
        end
        #1 areset = 0;
        model_reset();
    endtask

    task automatic test_count_sat();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1; bus2.in_data = 8'h01;
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 0; bus2.flush = 1;
        @(posedge clk);
        #1 bus2.flush = 0;
        n_vec++;
        if ({bus2.out_valid, bus2.out_sum, bus2.out_count, bus2.out_ovf_sticky} !== {1'b1, 8'h05, 2'd3, 1'b0}) begin
            n_err++;
            $display("FAIL count_sat: got v=%b s=%h c=%0d st=%b, need 1 05 3 0",
                     bus2.out_valid, bus2.out_sum, bus2.out_count, bus2.out_ovf_sticky);
        end
        bus2.out_ready = 1;
        @(posedge clk);
        #1 bus2.out_ready = 0;
        n_vec++;
        if ({bus2.out_valid, bus2.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL count_sat_release: got v=%b rdy=%b, need 0 1", bus2.out_valid, bus2.in_ready);
        end
    endtask

    task automatic test_random();
        bit v, f, r;
        logic [W-1:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom % 4) != 0;
            f = ($urandom % 8) == 0;
            r = ($urandom % 2) == 0;
            d = W'($urandom);
            cycle(v, d, f, r);
            n_vec++;
            if ({bus.in_ready, bus.out_valid, bus.ovf_pulse} !== {!m_hold, m_ovalid, m_pulse}) begin
                n_err++;
                $display("FAIL rand_ctrl[%0d]: got rdy=%b v=%b p=%b, need %b %b %b", i,
                         bus.in_ready, bus.out_valid, bus.ovf_pulse, !m_hold, m_ovalid, m_pulse);
            end
            if (m_ovalid) begin
                n_vec++;
                if ({bus.out_sum, bus.out_count, bus.out_ovf_sticky} !== {W'(m_osum), CNT_W'(m_ocnt), m_osticky}) begin
                    n_err++;
                    $display("FAIL rand_data[%0d]: got s=%h c=%0d st=%b, need %h %0d %b", i,
                             bus.out_sum, bus.out_count, bus.out_ovf_sticky, W'(m_osum), m_ocnt, m_osticky);
                end
            end
        end
    endtask

    initial begin
        clk = 0;
        areset = 0;
        n_vec = 0;
        n_err = 0;
        bus.in_valid = 0;  bus.in_data = '0;  bus.flush = 0;  bus.out_ready = 0;
        bus2.in_valid = 0; bus2.in_data = '0; bus2.flush = 0; bus2.out_ready = 0;
        model_reset();
        test_reset();
        test_ovf_pos();
        test_ovf_neg();
        test_flush_same_cycle();
        test_hold();
        test_reset_in_hold();
        test_count_sat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
